// File: rtl/dram_burst_sequencer.sv
// -----------------------------------------------------------------------------
// dram_burst_sequencer
//
// Command-level front end for the single-outstanding DRAM controller. Accepts
// one burst command (base address, stride, count, direction) and issues the
// transactions to the controller one at a time. Each transaction costs one
// ISSUE cycle (start pulse) followed by WAIT cycles until the controller's
// one-cycle done pulse. Burst completion is reported with a one-cycle pulse.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset (shared with controller)
//   cmd_valid/ready command handshake; ready only in IDLE and not in reset
//   cmd_addr        first transaction address
//   cmd_stride      per-transaction address increment (zero-extended)
//   cmd_count       number of transactions (0 = empty burst)
//   cmd_is_wr       burst direction, 1 = write
//   abort           finish the burst after the in-flight transaction
//   ctl_start       one-cycle start pulse to the controller
//   ctl_addr        current transaction address
//   ctl_is_wr       current transaction direction
//   ctl_done        controller done pulse (ignored outside WAIT)
//   busy            high in every state except IDLE
//   burst_done      one-cycle pulse at the end of a burst
//   burst_aborted   qualifies burst_done: burst ended early by abort
//   xfer_cnt        transactions completed in the current or last burst
//   timeout_err     sticky; a transaction waited TIMEOUT cycles without done
// -----------------------------------------------------------------------------
module dram_burst_sequencer #(
    parameter int ADDR_W   = 64,
    parameter int CNT_W    = 16,
    parameter int STRIDE_W = 32,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [STRIDE_W-1:0] cmd_stride,
    input  logic [CNT_W-1:0]    cmd_count,
    input  logic                cmd_is_wr,
    input  logic                abort,
    output logic                ctl_start,
    output logic [ADDR_W-1:0]   ctl_addr,
    output logic                ctl_is_wr,
    input  logic                ctl_done,
    output logic                busy,
    output logic                burst_done,
    output logic                burst_aborted,
    output logic [CNT_W-1:0]    xfer_cnt,
    output logic                timeout_err
);

    // Wait counter is wide enough to hold TIMEOUT and saturates there, so a
    // very long stall can never wrap and re-trigger or miss the watchdog.
    localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic WDOG_EN = (TIMEOUT != 0);
    localparam logic [WC_W-1:0] WC_LIMIT = WC_W'(TIMEOUT);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]          state_q,         state_d;
    logic                ctl_start_q,     ctl_start_d;
    logic [ADDR_W-1:0]   ctl_addr_q,      ctl_addr_d;
    logic                ctl_is_wr_q,     ctl_is_wr_d;
    logic [STRIDE_W-1:0] stride_q,        stride_d;
    logic [CNT_W-1:0]    remaining_q,     remaining_d;
    logic [CNT_W-1:0]    xfer_cnt_q,      xfer_cnt_d;
    logic                abort_flag_q,    abort_flag_d;
    logic [WC_W-1:0]     wait_cnt_q,      wait_cnt_d;
    logic                timeout_err_q,   timeout_err_d;
    logic                burst_done_q,    burst_done_d;
    logic                burst_aborted_q, burst_aborted_d;

    logic [ADDR_W-1:0]   stride_ext_s;
    logic [WC_W-1:0]     wait_inc_s;
    logic                abort_seen_s;
    logic                last_xfer_s;

    assign stride_ext_s = ADDR_W'(stride_q);
    assign wait_inc_s   = (wait_cnt_q == WC_LIMIT) ? wait_cnt_q : (wait_cnt_q + WC_W'(1));
    // An abort arriving together with a non-final done still stops the burst
    // after that transaction instead of issuing one more.
    assign abort_seen_s = abort_flag_q | abort;
    assign last_xfer_s  = (remaining_q == CNT_W'(1));

    // Next-state and next-output computation for the burst FSM.
    always_comb begin
        state_d         = state_q;
        ctl_start_d     = 1'b0;
        ctl_addr_d      = ctl_addr_q;
        ctl_is_wr_d     = ctl_is_wr_q;
        stride_d        = stride_q;
        remaining_d     = remaining_q;
        xfer_cnt_d      = xfer_cnt_q;
        abort_flag_d    = abort_flag_q;
        wait_cnt_d      = wait_cnt_q;
        timeout_err_d   = timeout_err_q;
        burst_done_d    = 1'b0;
        burst_aborted_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // cmd_ready is only low in IDLE while reset is high, and the
                // register block overrides everything then.
                if (cmd_valid) begin
                    ctl_addr_d    = cmd_addr;
                    stride_d      = cmd_stride;
                    ctl_is_wr_d   = cmd_is_wr;
                    remaining_d   = cmd_count;
                    xfer_cnt_d    = {CNT_W{1'b0}};
                    timeout_err_d = 1'b0;
                    abort_flag_d  = 1'b0;
                    if (cmd_count == {CNT_W{1'b0}}) begin
                        state_d      = ST_FINISH;
                        burst_done_d = 1'b1;
                    end else begin
                        state_d     = ST_ISSUE;
                        ctl_start_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                wait_cnt_d = {WC_W{1'b0}};
                state_d    = ST_WAIT;
                if (abort) begin
                    abort_flag_d = 1'b1;
                end else begin
                    abort_flag_d = abort_flag_q;
                end
            end

            ST_WAIT: begin
                wait_cnt_d = wait_inc_s;
                if (abort) begin
                    abort_flag_d = 1'b1;
                end else begin
                    abort_flag_d = abort_flag_q;
                end
                if (ctl_done) begin
                    xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    ctl_addr_d  = ctl_addr_q + stride_ext_s;
                    if (last_xfer_s || abort_seen_s) begin
                        state_d         = ST_FINISH;
                        burst_done_d    = 1'b1;
                        // Work was left over only if this was not the last one.
                        burst_aborted_d = abort_seen_s && !last_xfer_s;
                    end else begin
                        state_d     = ST_ISSUE;
                        ctl_start_d = 1'b1;
                    end
                end else if (WDOG_EN && (wait_inc_s == WC_LIMIT)) begin
                    timeout_err_d = 1'b1;
                end else begin
                    timeout_err_d = timeout_err_q;
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            ctl_start_q     <= 1'b0;
            ctl_addr_q      <= {ADDR_W{1'b0}};
            ctl_is_wr_q     <= 1'b0;
            stride_q        <= {STRIDE_W{1'b0}};
            remaining_q     <= {CNT_W{1'b0}};
            xfer_cnt_q      <= {CNT_W{1'b0}};
            abort_flag_q    <= 1'b0;
            wait_cnt_q      <= {WC_W{1'b0}};
            timeout_err_q   <= 1'b0;
            burst_done_q    <= 1'b0;
            burst_aborted_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ctl_start_q     <= ctl_start_d;
            ctl_addr_q      <= ctl_addr_d;
            ctl_is_wr_q     <= ctl_is_wr_d;
            stride_q        <= stride_d;
            remaining_q     <= remaining_d;
            xfer_cnt_q      <= xfer_cnt_d;
            abort_flag_q    <= abort_flag_d;
            wait_cnt_q      <= wait_cnt_d;
            timeout_err_q   <= timeout_err_d;
            burst_done_q    <= burst_done_d;
            burst_aborted_q <= burst_aborted_d;
        end
    end

    // cmd_ready is held low during reset so no command is taken in that cycle.
    assign cmd_ready     = (state_q == ST_IDLE) && !reset;
    assign busy          = (state_q != ST_IDLE);
    assign ctl_start     = ctl_start_q;
    assign ctl_addr      = ctl_addr_q;
    assign ctl_is_wr     = ctl_is_wr_q;
    assign burst_done    = burst_done_q;
    assign burst_aborted = burst_aborted_q;
    assign xfer_cnt      = xfer_cnt_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_dram_burst_sequencer.sv
module tb_dram_burst_sequencer;

    localparam int AW  = 64;
    localparam int CW  = 16;
    localparam int SW  = 32;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [SW-1:0] cmd_stride = '0;
    logic [CW-1:0] cmd_count = '0;
    logic          cmd_is_wr = 1'b0;
    logic          abort = 1'b0;
    logic          ctl_start;
    logic [AW-1:0] ctl_addr;
    logic          ctl_is_wr;
    logic          ctl_done;
    logic          busy;
    logic          burst_done;
    logic          burst_aborted;
    logic [CW-1:0] xfer_cnt;
    logic          timeout_err;

    dram_burst_sequencer #(
        .ADDR_W(AW), .CNT_W(CW), .STRIDE_W(SW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_stride(cmd_stride),
        .cmd_count(cmd_count), .cmd_is_wr(cmd_is_wr),
        .abort(abort),
        .ctl_start(ctl_start), .ctl_addr(ctl_addr), .ctl_is_wr(ctl_is_wr),
        .ctl_done(ctl_done),
        .busy(busy), .burst_done(burst_done), .burst_aborted(burst_aborted),
        .xfer_cnt(xfer_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- controller model (written by its own process) --------
    int ctl_lat = 4;   // written by main only
    bit stray   = 1'b0; // written by main only

    initial begin
        int cnt;
        cnt = 0;
        ctl_done = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                cnt = 0;
                ctl_done = 1'b0;
            end else if (ctl_start) begin
                cnt = ctl_lat;
                ctl_done = stray;
            end else if (cnt > 0) begin
                cnt--;
                ctl_done = (cnt == 0) || stray;
            end else begin
                ctl_done = stray;
            end
        end
    end

    // ---------------- behavioural model + observation log ------------------
    bit            chk_en = 1'b0; // written by main only
    int            cyc = 0;
    bit            m_idle = 1'b1, m_start = 1'b0, m_done = 1'b0, m_abt = 1'b0;
    bit            m_wr = 1'b0, m_req = 1'b0, m_terr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [SW-1:0] m_stride = '0;
    int            m_left = 0, m_xfer = 0, m_wait = 0;

    logic [63:0]   st_addr[$];
    bit            st_wr[$];
    int            st_cyc[$];
    int            bd_n = 0, bd_cyc = -1, acc_cyc = -1, terr_rise = -1;
    int            bd_xfer = 0;
    bit            bd_abt = 1'b0, terr_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("cmd_ready",     64'(cmd_ready),     64'(m_idle && !reset));
            chk("busy",          64'(busy),          64'(!m_idle));
            chk("ctl_start",     64'(ctl_start),     64'(m_start));
            chk("burst_done",    64'(burst_done),    64'(m_done));
            chk("burst_aborted", 64'(burst_aborted), 64'(m_done && m_abt));
            chk("ctl_addr",      ctl_addr,           m_addr);
            chk("ctl_is_wr",     64'(ctl_is_wr),     64'(m_wr));
            chk("xfer_cnt",      64'(xfer_cnt),      64'(m_xfer));
            chk("timeout_err",   64'(timeout_err),   64'(m_terr));
        end
        if (!reset) begin
            if (ctl_start) begin
                st_addr.push_back(ctl_addr);
                st_wr.push_back(ctl_is_wr);
                st_cyc.push_back(cyc);
            end
            if (burst_done) begin
                bd_n++;
                bd_cyc  = cyc;
                bd_xfer = int'(xfer_cnt);
                bd_abt  = burst_aborted;
            end
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
        end
        if (timeout_err && !terr_prev) terr_rise = cyc;
        terr_prev = timeout_err;

        // Predict the next cycle from this cycle's inputs.
        if (reset) begin
            m_idle = 1'b1; m_start = 1'b0; m_done = 1'b0; m_abt = 1'b0;
            m_wr = 1'b0; m_req = 1'b0; m_terr = 1'b0;
            m_addr = '0; m_stride = '0; m_left = 0; m_xfer = 0; m_wait = 0;
        end else if (m_idle) begin
            m_done = 1'b0;
            if (cmd_valid) begin
                m_addr = cmd_addr; m_stride = cmd_stride; m_wr = cmd_is_wr;
                m_left = int'(cmd_count); m_xfer = 0; m_terr = 1'b0; m_req = 1'b0;
                m_idle = 1'b0;
                m_abt  = 1'b0;
                if (cmd_count == 0) m_done = 1'b1;
                else                m_start = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
            m_idle = 1'b1;
        end else if (m_start) begin
            m_start = 1'b0;
            m_wait = 0;
            if (abort) m_req = 1'b1;
        end else begin
            m_wait++;
            if (abort) m_req = 1'b1;
            if (ctl_done) begin
                m_xfer++;
                m_left--;
                m_addr = m_addr + AW'(m_stride);
                if (m_left == 0) begin
                    m_done = 1'b1; m_abt = 1'b0;
                end else if (m_req) begin
                    m_done = 1'b1; m_abt = 1'b1;
                end else begin
                    m_start = 1'b1;
                end
            end else if (m_wait == TMO) begin
                m_terr = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic send(input logic [AW-1:0] a, input logic [SW-1:0] s,
                        input logic [CW-1:0] n, input bit wr);
        int k;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(posedge clk); #1; k++;
        end
        chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_addr = a; cmd_stride = s; cmd_count = n; cmd_is_wr = wr;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n0, k;
        n0 = bd_n;
        k = 0;
        while (bd_n == n0 && k < budget) begin
            @(posedge clk); #1; k++;
        end
        chk("burst_done_seen", 64'(bd_n != n0), 64'd1);
    endtask

    task automatic wait_starts(input int target);
        int k;
        k = 0;
        while (st_addr.size() < target && k < 200) begin
            @(posedge clk); #1; k++;
        end
        chk("start_seen", 64'(st_addr.size() >= target), 64'd1);
    endtask

    // ---------------- directed sequence --------------------------------------
    initial begin
        int n0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        // Reset state
        chk("rst_ctl_start", 64'(ctl_start), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_xfer_cnt",  64'(xfer_cnt),  64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 64'(cmd_ready), 64'd1);

        // Basic 3-transaction write burst
        ctl_lat = 4;
        n0 = st_addr.size();
        send(64'h1000, 32'h40, 16'd3, 1'b1);
        wait_done(200);
        chk("t1_nstart", 64'(st_addr.size() - n0), 64'd3);
        chk("t1_addr0",  st_addr[n0],     64'h1000);
        chk("t1_addr1",  st_addr[n0 + 1], 64'h1040);
        chk("t1_addr2",  st_addr[n0 + 2], 64'h1080);
        chk("t1_wr2",    64'(st_wr[n0 + 2]), 64'd1);
        chk("t1_xfer",   64'(bd_xfer), 64'd3);
        chk("t1_abt",    64'(bd_abt),  64'd0);
        chk("t1_lat",    64'(bd_cyc - st_cyc[n0 + 2]), 64'd5);
        chk("t1_addr_hold", ctl_addr, 64'h10C0);

        // Stray done while idle must be ignored
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stray_xfer", 64'(xfer_cnt), 64'd3);

        // Zero-count burst
        n0 = st_addr.size();
        send(64'h2000, 32'h10, 16'd0, 1'b0);
        wait_done(20);
        chk("t2_nstart", 64'(st_addr.size() - n0), 64'd0);
        chk("t2_lat",    64'(bd_cyc - acc_cyc), 64'd1);
        chk("t2_xfer",   64'(bd_xfer), 64'd0);

        // Abort during the second WAIT of a 5-transaction burst
        n0 = st_addr.size();
        send(64'h3000, 32'h100, 16'd5, 1'b0);
        wait_starts(n0 + 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_done(200);
        chk("t3_nstart", 64'(st_addr.size() - n0), 64'd2);
        chk("t3_xfer",   64'(bd_xfer), 64'd2);
        chk("t3_abt",    64'(bd_abt),  64'd1);

        // Address wrap
        n0 = st_addr.size();
        send(64'hFFFF_FFFF_FFFF_FFC0, 32'h40, 16'd2, 1'b1);
        wait_done(200);
        chk("t4_addr0", st_addr[n0],     64'hFFFF_FFFF_FFFF_FFC0);
        chk("t4_addr1", st_addr[n0 + 1], 64'h0);

        // Watchdog: done withheld for 20 cycles
        ctl_lat = 20;
        n0 = st_addr.size();
        send(64'h5000, 32'h8, 16'd1, 1'b0);
        wait_done(200);
        chk("t5_terr",      64'(timeout_err), 64'd1);
        chk("t5_terr_rise", 64'(terr_rise - st_cyc[n0]), 64'd9);
        chk("t5_xfer",      64'(bd_xfer), 64'd1);
        ctl_lat = 4;
        send(64'h6000, 32'h4, 16'd1, 1'b1);
        chk("t5_terr_clr", 64'(timeout_err), 64'd0);
        wait_done(200);

        // Reset mid-WAIT, then a fresh burst
        ctl_lat = 6;
        n0 = st_addr.size();
        send(64'h7000, 32'h20, 16'd4, 1'b1);
        wait_starts(n0 + 2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t6_start", 64'(ctl_start), 64'd0);
        chk("t6_addr",  ctl_addr,       64'h0);
        chk("t6_busy",  64'(busy),      64'd0);
        chk("t6_xfer",  64'(xfer_cnt),  64'd0);
        chk("t6_wr",    64'(ctl_is_wr), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t6_ready", 64'(cmd_ready), 64'd1);
        ctl_lat = 3;
        n0 = st_addr.size();
        send(64'h8000, 32'h10, 16'd2, 1'b0);
        wait_done(200);
        chk("t6_addr0", st_addr[n0],     64'h8000);
        chk("t6_addr1", st_addr[n0 + 1], 64'h8010);
        chk("t6_nxfer", 64'(bd_xfer), 64'd2);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
